fixed_point_divider_param: RTL and testbench

- Parametrised successor to the team's 10-bit fixed-point divider.
- Divides two W-bit fixed-point operands with F fractional bits using an iterative restoring shift-subtract datapath, one quotient bit per clock.
- Adds two things the earlier block lacks: a signed two's-complement mode, and saturation on overflow.
- Sits as a multi-cycle arithmetic unit behind a START/BUSY/VALID handshake.

---
 rtl/fixed_point_divider_param.sv | 198 +++++++++++++++++++
 tb/tb_fixed_point_divider_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider_param.sv
// ---------------------------------------------------------------------------
// fixed_point_divider_param
//
// Purpose:
//    Iterative restoring divider for W-bit fixed-point operands with F
//    fractional bits (Q(W-F).F). Produces one quotient bit per clock from
//    (A << F) / B, truncated toward zero, then clamps the result into the
//    W-bit output range and flags saturation. SIGNED=1 selects
//    two's-complement operands/result.
//
// Ports:
//    CLK    in   1  clock, all state changes on the rising edge
//    SCLR   in   1  synchronous active-high clear, dominates all inputs
//    AIN    in   W  dividend, sampled on an accepted START
//    BIN    in   W  divisor, sampled on an accepted START
//    START  in   1  request, accepted only while BUSY=0
//    QOUT   out  W  quotient, held until the next result or SCLR
//    DVZ    out  1  divide-by-zero flag for the current QOUT
//    OVF    out  1  saturation flag for the current QOUT
//    BUSY   out  1  division in progress
//    VALID  out  1  one-cycle pulse when QOUT/DVZ/OVF are written
// ---------------------------------------------------------------------------
module fixed_point_divider_param #(
   parameter int W      = 10,
   parameter int F      = 5,
   parameter int SIGNED = 0
) (
   input  logic         CLK,
   input  logic         SCLR,
   input  logic [W-1:0] AIN,
   input  logic [W-1:0] BIN,
   input  logic         START,
   output logic [W-1:0] QOUT,
   output logic         DVZ,
   output logic         OVF,
   output logic         BUSY,
   output logic         VALID
);

   localparam int N  = W + F;            // dividend / raw quotient width
   localparam int CW = $clog2(N + 1);

   localparam logic [N:0]   ONE    = 1;
   localparam logic [N:0]   LIM_U  = ONE << W;        // 2^W
   localparam logic [N:0]   LIM_SN = ONE << (W - 1);  // 2^(W-1)
   localparam logic [N:0]   LIM_SP = LIM_SN - ONE;    // 2^(W-1)-1
   localparam logic [W-1:0] Q_MAXU = '1;
   localparam logic [W-1:0] Q_MAXS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] Q_MINS = {1'b1, {(W-1){1'b0}}};

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_div;     // dividend, consumed MSB first
   logic [W-1:0]    r_rem;     // partial remainder, always < divisor
   logic [W-1:0]    r_bmag;    // divisor magnitude
   logic [N-1:0]    r_quo;     // quotient bits gathered so far
   logic            r_neg;     // result sign
   logic [W-1:0]    r_qout;
   logic            r_dvz;
   logic            r_ovf;
   logic            r_valid;

   wire             w_sgn = (SIGNED != 0);
   logic [W-1:0]    w_amag;
   logic [W-1:0]    w_bmag;
   logic            w_neg;
   logic            w_bzero;
   logic            w_last;
   logic [W:0]      w_shift;
   logic            w_qbit;
   logic [W-1:0]    w_rem_sub;
   logic [N-1:0]    w_m;
   logic [N:0]      w_m_ext;
   logic [W-1:0]    w_qout_res;
   logic            w_ovf_res;

   // Operand conditioning. Negating -2^(W-1) yields 2^(W-1), which is still
   // representable as a W-bit unsigned magnitude.
   always_comb begin
      w_amag  = (w_sgn && AIN[W-1]) ? -AIN : AIN;
      w_bmag  = (w_sgn && BIN[W-1]) ? -BIN : BIN;
      w_neg   = w_sgn && (AIN[W-1] ^ BIN[W-1]);
      w_bzero = (BIN == '0);
   end

   // One restoring step. The shifted remainder needs W+1 bits; after a
   // successful subtract it is below the divisor again, so W bits suffice.
   always_comb begin
      w_shift   = {r_rem, r_div[N-1]};
      w_qbit    = (w_shift >= {1'b0, r_bmag});
      w_rem_sub = w_shift[W-1:0] - r_bmag;
      w_last    = (r_cnt == CW'(N - 1));
      w_m       = (r_quo << 1) | N'(w_qbit);
      w_m_ext   = {1'b0, w_m};
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK) begin
      if (SCLR) r_state <= ST_IDLE;
      else      r_state <= w_state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (START && !w_bzero) w_state_next = ST_RUN;
         ST_RUN:  if (w_last)            w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs and result clamping ----------------
   always_comb begin
      BUSY       = (r_state == ST_RUN);
      w_qout_res = w_m[W-1:0];
      w_ovf_res  = 1'b0;
      if (!w_sgn) begin
         if (w_m_ext >= LIM_U) begin
            w_qout_res = Q_MAXU;
            w_ovf_res  = 1'b1;
         end
      end else if (!r_neg) begin
         if (w_m_ext > LIM_SP) begin
            w_qout_res = Q_MAXS;
            w_ovf_res  = 1'b1;
         end
      end else begin
         // A zero magnitude negates to zero, so a zero quotient stays 0.
         if (w_m_ext > LIM_SN) begin
            w_qout_res = Q_MINS;
            w_ovf_res  = 1'b1;
         end else begin
            w_qout_res = -w_m[W-1:0];
         end
      end
   end

   // ---------------- Datapath and result registers ----------------
   always_ff @(posedge CLK) begin
      if (SCLR) begin
         r_cnt   <= '0;
         r_div   <= '0;
         r_rem   <= '0;
         r_bmag  <= '0;
         r_quo   <= '0;
         r_neg   <= 1'b0;
         r_qout  <= '0;
         r_dvz   <= 1'b0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (START) begin
                  if (w_bzero) begin
                     r_qout  <= '0;
                     r_dvz   <= 1'b1;
                     r_ovf   <= 1'b0;
                     r_valid <= 1'b1;
                  end else begin
                     r_div  <= N'(w_amag) << F;
                     r_bmag <= w_bmag;
                     r_neg  <= w_neg;
                     r_rem  <= '0;
                     r_quo  <= '0;
                     r_cnt  <= '0;
                  end
               end
            end
            ST_RUN: begin
               r_rem <= w_qbit ? w_rem_sub : w_shift[W-1:0];
               r_div <= r_div << 1;
               r_quo <= w_m;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_qout  <= w_qout_res;
                  r_ovf   <= w_ovf_res;
                  r_dvz   <= 1'b0;
                  r_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign QOUT  = r_qout;
   assign DVZ   = r_dvz;
   assign OVF   = r_ovf;
   assign VALID = r_valid;

endmodule

// File: tb/tb_fixed_point_divider_param.sv
// ---------------------------------------------------------------------------
// tb_fixed_point_divider_param
//
// Drives an unsigned and a signed instance (W=10, F=5) with identical
// stimulus and compares both against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fixed_point_divider_param;

   localparam int W = 10;
   localparam int F = 5;
   localparam int N = W + F;

   logic         CLK = 1'b0;
   logic         SCLR;
   logic         START;
   logic [W-1:0] AIN;
   logic [W-1:0] BIN;

   logic [W-1:0] qout_u, qout_s;
   logic         dvz_u, dvz_s, ovf_u, ovf_s, busy_u, busy_s, valid_u, valid_s;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   fixed_point_divider_param #(.W(W), .F(F), .SIGNED(0)) u_uns (
      .CLK(CLK), .SCLR(SCLR), .AIN(AIN), .BIN(BIN), .START(START),
      .QOUT(qout_u), .DVZ(dvz_u), .OVF(ovf_u), .BUSY(busy_u), .VALID(valid_u)
   );

   fixed_point_divider_param #(.W(W), .F(F), .SIGNED(1)) u_sgn (
      .CLK(CLK), .SCLR(SCLR), .AIN(AIN), .BIN(BIN), .START(START),
      .QOUT(qout_s), .DVZ(dvz_s), .OVF(ovf_s), .BUSY(busy_s), .VALID(valid_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: exact (A * 2^F) / B truncated toward zero, then range check.
   // Returns {dvz, ovf, q}.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit sgn);
      longint av, bv, m, pmax, nmax;
      bit     neg;
      if (b == '0) return {2'b10, W'(0)};
      av   = sgn ? longint'($signed(a)) : longint'(a);
      bv   = sgn ? longint'($signed(b)) : longint'(b);
      neg  = (av < 0) != (bv < 0);
      if (av < 0) av = -av;
      if (bv < 0) bv = -bv;
      m    = (av * (longint'(1) << F)) / bv;
      pmax = (longint'(1) << (W - 1)) - 1;
      nmax = longint'(1) << (W - 1);
      if (!sgn) begin
         if (m >= (longint'(1) << W)) return {2'b01, {W{1'b1}}};
         return {2'b00, W'(m)};
      end
      if (!neg || m == 0) begin
         if (m > pmax) return {2'b01, W'(pmax)};
         return {2'b00, W'(m)};
      end
      if (m > nmax) return {2'b01, W'(-nmax)};
      return {2'b00, W'(-m)};
   endfunction

   // Issue one operation and wait for its result. restart_at >= 0 raises a
   // second START after that many post-start samples; it must be ignored.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int restart_at);
      logic [W+1:0] eu, es;
      int           idx, busy_cnt, exp_lat;
      eu      = model(a, b, 1'b0);
      es      = model(a, b, 1'b1);
      exp_lat = (b == '0) ? 0 : N;
      AIN = a; BIN = b; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      AIN = W'($urandom); BIN = W'($urandom);
      idx = 0; busy_cnt = 0;
      while (!valid_u && idx < N + 10) begin
         if (busy_u) busy_cnt++;
         if (idx == restart_at) begin
            START = 1'b1;
            AIN = W'($urandom); BIN = W'($urandom_range(1, (1 << W) - 1));
         end
         @(posedge CLK); #1;
         START = 1'b0;
         idx++;
      end
      check("valid_seen", {31'd0, valid_u}, 32'd1);
      check("valid_sgn",  {31'd0, valid_s}, 32'd1);
      check("latency",    idx,      exp_lat);
      check("busy_cycles", busy_cnt, exp_lat);
      check("busy_end",   {30'd0, busy_u, busy_s}, 32'd0);
      check("uns_q",   qout_u, eu[W-1:0]);
      check("uns_dvz", dvz_u,  eu[W+1]);
      check("uns_ovf", ovf_u,  eu[W]);
      check("sgn_q",   qout_s, es[W-1:0]);
      check("sgn_dvz", dvz_s,  es[W+1]);
      check("sgn_ovf", ovf_s,  es[W]);
      $display("op a=0x%03h b=0x%03h lat=%0d uns q=0x%03h d=%0d o=%0d sgn q=0x%03h d=%0d o=%0d",
               a, b, idx, qout_u, dvz_u, ovf_u, qout_s, dvz_s, ovf_s);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_q"},   {qout_u, qout_s}, 32'd0);
      check({tag, "_flg"}, {26'd0, dvz_u, dvz_s, ovf_u, ovf_s, busy_u, busy_s}, 32'd0);
      check({tag, "_vld"}, {30'd0, valid_u, valid_s}, 32'd0);
   endtask

   // SCLR during a run: everything cleared, no VALID afterwards.
   task automatic do_abort(input logic [W-1:0] a, input logic [W-1:0] b);
      int vcnt;
      AIN = a; BIN = b; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (4) begin @(posedge CLK); #1; end
      SCLR = 1'b1;
      @(posedge CLK); #1;
      SCLR = 1'b0;
      check_cleared("abort");
      vcnt = 0;
      repeat (N + 4) begin
         @(posedge CLK); #1;
         if (valid_u || valid_s) vcnt++;
      end
      check("abort_no_valid", vcnt, 0);
      $display("abort a=0x%03h b=0x%03h valid_after=%0d", a, b, vcnt);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      SCLR = 1'b1; START = 1'b0; AIN = '0; BIN = '0;
      repeat (2) @(posedge CLK);
      #1;
      check_cleared("reset");
      SCLR = 1'b0;
      @(posedge CLK); #1;

      do_op(10'h0A0, 10'h020, -1);   // 5.0 / 1.0
      do_op(10'h020, 10'h060, -1);   // 1.0 / 3.0
      do_op(10'h0A0, 10'h000, -1);   // divide by zero
      do_op(10'h3FF, 10'h001, -1);   // unsigned overflow
      do_op(10'h360, 10'h040, -1);   // -5.0 / 2.0
      do_op(10'h3E0, 10'h060, -1);   // -1.0 / 3.0
      do_op(10'h200, 10'h3E0, -1);   // -16.0 / -1.0 saturates
      do_op(10'h200, 10'h020, -1);   // most negative / 1.0, fits exactly
      do_op(10'h000, 10'h3E0, -1);   // zero quotient
      do_op(10'h0A0, 10'h020, 3);    // second START ignored
      do_abort(10'h3FF, 10'h001);
      do_op(10'h123, 10'h045, -1);
      do_op(10'h1FF, 10'h3FF, -1);   // back-to-back (START in VALID cycle)

      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK); #1;
         end
         do_op(ra, rb, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N - 3)) : -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
